// File: rtl/alu_issue_arbiter_pkg.sv
// Shared definitions for the ALU issue arbiter: default widths, the ARM ALU
// opcode map, flag bit positions and the compare/test opcode classifier.
package alu_issue_arbiter_pkg;

  localparam int DW_D  = 32;
  localparam int OPW_D = 5;
  localparam int FW_D  = 4;

  // Flag vector is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [OPW_D-1:0] {
    OP_AND    = 5'd0,
    OP_XOR    = 5'd1,
    OP_SUB    = 5'd2,
    OP_RSB    = 5'd3,
    OP_ADD    = 5'd4,
    OP_ADC    = 5'd5,
    OP_SBC    = 5'd6,
    OP_RSC    = 5'd7,
    OP_TST    = 5'd8,
    OP_TEQ    = 5'd9,
    OP_CMP    = 5'd10,
    OP_CMN    = 5'd11,
    OP_ORR    = 5'd12,
    OP_MOV    = 5'd13,
    OP_BIC    = 5'd14,
    OP_MVN    = 5'd15,
    OP_BYPASS = 5'd16,
    OP_INC    = 5'd17
  } alu_op_e;

  // TST/TEQ/CMP/CMN only update flags; their result is never written back.
  function automatic logic is_test_op(input logic [OPW_D-1:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Requester and response handshake bundle for the ALU issue arbiter.
//   req0_* / req1_* : valid/ready request channels carrying a, b, op, s
//   rsp_*           : valid/ready response channel carrying result, id, wr
// master = requesters + response consumer, slave = the arbiter.
interface alu_issue_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [OPW-1:0] req0_op;
  logic           req0_s;

  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [OPW-1:0] req1_op;
  logic           req1_s;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_result;
  logic           rsp_wr;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_s,
    output req1_valid, req1_a, req1_b, req1_op, req1_s,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_wr
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_s,
    input  req1_valid, req1_a, req1_b, req1_op, req1_s,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_wr
  );
endinterface

// File: rtl/alu_issue_arbiter_rr.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   en         : downstream can take a grant this cycle
//   gnt[1:0]   : one-hot grant (zero when en is low)
// The pointer remembers who won last and only moves when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  // last_gnt1 = 1 means requester 1 won most recently, so requester 0 is
  // favoured on the next contention. Reset leaves requester 0 favoured.
  logic last_gnt1;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_gnt1 ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     last_gnt1 <= 1'b1;
    else if (|gnt) last_gnt1 <= gnt[1];
  end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one combinational ARM ALU between the execute
// datapath (port 0) and the address/aux unit (port 1).
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : req0/req1 request channels and the response channel
//   flags_q         : architectural {N,Z,C,V}
//   flags_ld/_val   : direct flag load, wins over an ALU flag update
//   alu_*           : drive to / result from the external ALU
// Pipeline: round-robin accept -> operand stage S1 (drives ALU) -> response R.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int DW  = DW_D,
  parameter int OPW = OPW_D,
  parameter int FW  = FW_D
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_arbiter_if.slave bus,
  output logic [FW-1:0]  flags_q,
  input  logic           flags_ld,
  input  logic [FW-1:0]  flags_ld_val,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [FW-1:0]  alu_flags,
  output logic           alu_s,
  output logic           alu_out_en,
  input  logic [DW-1:0]  alu_result,
  input  logic [FW-1:0]  alu_flags_out
);
  // Operand stage
  logic           s1_valid;
  logic [DW-1:0]  s1_a, s1_b;
  logic [OPW-1:0] s1_op;
  logic           s1_s;
  logic           s1_id;

  logic       advance, can_accept;
  logic [1:0] gnt;

  assign advance    = s1_valid & (~bus.rsp_valid | bus.rsp_ready);
  // Readies are held low during reset so nothing is taken on a reset edge.
  assign can_accept = ~reset & (~s1_valid | advance);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (can_accept),
    .gnt   (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_s     <= 1'b0;
      s1_id    <= 1'b0;
    end else if (gnt[0]) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.req0_a;
      s1_b     <= bus.req0_b;
      s1_op    <= bus.req0_op;
      s1_s     <= bus.req0_s;
      s1_id    <= 1'b0;
    end else if (gnt[1]) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.req1_a;
      s1_b     <= bus.req1_b;
      s1_op    <= bus.req1_op;
      s1_s     <= bus.req1_s;
      s1_id    <= 1'b1;
    end else if (advance) begin
      // Operands are kept so the ALU inputs stay quiet while idle.
      s1_valid <= 1'b0;
    end
  end

  // ALU drive straight from S1; an empty stage never requests a flag update
  // or a write-back.
  assign alu_a      = s1_a;
  assign alu_b      = s1_b;
  assign alu_op     = s1_op;
  assign alu_s      = s1_valid & s1_s;
  assign alu_out_en = s1_valid & ~is_test_op(s1_op);
  // Flags reach the ALU from the register itself: a commit at this edge is
  // already visible to the carry-using op that just entered S1.
  assign alu_flags  = flags_q;

  // Response register
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_wr     <= 1'b0;
    end else if (advance) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_result <= alu_result;
      bus.rsp_id     <= s1_id;
      bus.rsp_wr     <= alu_out_en;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end

  // Flag register: a direct load overrides a same-cycle ALU commit.
  always_ff @(posedge clk) begin
    if (reset)                    flags_q <= '0;
    else if (flags_ld)            flags_q <= flags_ld_val;
    else if (advance && s1_s)     flags_q <= alu_flags_out;
  end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  flags_q;
  logic        flags_ld;
  logic [3:0]  flags_ld_val;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flags, alu_flags_out;
  logic        alu_s, alu_out_en;

  int checks = 0;
  int errors = 0;

  alu_issue_arbiter_if #(.DW(32), .OPW(5)) bus ();

  alu_issue_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .flags_q       (flags_q),
    .flags_ld      (flags_ld),
    .flags_ld_val  (flags_ld_val),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_flags     (alu_flags),
    .alu_s         (alu_s),
    .alu_out_en    (alu_out_en),
    .alu_result    (alu_result),
    .alu_flags_out (alu_flags_out)
  );

  always #5 clk = ~clk;

  // Reference ARM ALU standing in for the external block: {flags, result}.
  function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] f);
    logic [32:0] s;
    logic [31:0] x, y, r;
    logic cin, c, v, arith;
    x = a; y = b; cin = 1'b0; arith = 1'b1; r = '0;
    case (op)
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = f[1];
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_SBC:         begin y = ~b; cin = f[1]; end
      OP_RSC:         begin x = b; y = ~a; cin = f[1]; end
      OP_INC:         begin y = '0; cin = 1'b1; end
      default:        arith = 1'b0;
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    if (arith) begin
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      c = f[1];
      v = f[0];
      case (op)
        OP_AND, OP_TST: r = a & b;
        OP_XOR, OP_TEQ: r = a ^ b;
        OP_ORR:         r = a | b;
        OP_MOV:         r = b;
        OP_BIC:         r = a & ~b;
        OP_MVN:         r = ~b;
        OP_BYPASS:      r = a;
        default:        r = '0;
      endcase
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb begin
    {alu_flags_out, alu_result} = 36'd0;
    {alu_flags_out, alu_result} = alu_model(alu_op, alu_a, alu_b, alu_flags);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_s = s;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_s = s;
    end
  endtask

  initial begin
    reset = 1'b1; flags_ld = 1'b0; flags_ld_val = 4'd0;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    cyc(); cyc();

    // Reset state: a valid request is not accepted while reset is held
    set_req(0, 1'b1, OP_ADD, 32'h1, 32'h1, 1'b0);
    settle();
    chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
    chk("rst_flags",      64'(flags_q), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_alu_a",      64'(alu_a), 64'd0);
    chk("rst_alu_out_en", 64'(alu_out_en), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    cyc();
    reset = 1'b0;

    // ADD 0xFB + 0xB
    set_req(0, 1'b1, OP_ADD, 32'hFB, 32'hB, 1'b1);
    settle();
    chk("add_req0_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("add_alu_a",      64'(alu_a), 64'hFB);
    chk("add_alu_s",      64'(alu_s), 64'd1);
    chk("add_rsp_pend",   64'(bus.rsp_valid), 64'd0);
    cyc();
    chk("add_rsp_valid",  64'(bus.rsp_valid), 64'd1);
    chk("add_result",     64'(bus.rsp_result), 64'h106);
    chk("add_id",         64'(bus.rsp_id), 64'd0);
    chk("add_wr",         64'(bus.rsp_wr), 64'd1);
    chk("add_flags",      64'(flags_q), 64'd0);

    // SUB 1,1 then ADC 0xF,0xF back to back; ADC sees C from SUB
    set_req(0, 1'b1, OP_SUB, 32'h1, 32'h1, 1'b1);
    cyc();
    set_req(0, 1'b1, OP_ADC, 32'hF, 32'hF, 1'b1);
    settle();
    chk("b2b_req0_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("sub_result",     64'(bus.rsp_result), 64'd0);
    chk("sub_flags",      64'(flags_q), 64'b0110);
    chk("adc_alu_flags",  64'(alu_flags), 64'b0110);
    chk("adc_alu_op",     64'(alu_op), 64'(OP_ADC));
    cyc();
    chk("adc_result",     64'(bus.rsp_result), 64'h1F);
    chk("adc_flags",      64'(flags_q), 64'd0);

    // req1 CMP 0xF,0xF: flags only, no write-back
    set_req(1, 1'b1, OP_CMP, 32'hF, 32'hF, 1'b1);
    settle();
    chk("cmp_req1_ready", 64'(bus.req1_ready), 64'd1);
    chk("cmp_req0_ready", 64'(bus.req0_ready), 64'd0);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("cmp_alu_out_en", 64'(alu_out_en), 64'd0);
    cyc();
    chk("cmp_rsp_valid",  64'(bus.rsp_valid), 64'd1);
    chk("cmp_wr",         64'(bus.rsp_wr), 64'd0);
    chk("cmp_id",         64'(bus.rsp_id), 64'd1);
    chk("cmp_flags",      64'(flags_q), 64'b0110);

    // Both valid for 4 cycles: grants alternate 0,1,0,1
    set_req(0, 1'b1, OP_ADD, 32'd1,  32'd2,  1'b0);
    set_req(1, 1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
    settle();
    chk("rr0_req0_ready", 64'(bus.req0_ready), 64'd1);
    chk("rr0_req1_ready", 64'(bus.req1_ready), 64'd0);
    cyc();
    chk("rr1_req1_ready", 64'(bus.req1_ready), 64'd1);
    chk("rr1_req0_ready", 64'(bus.req0_ready), 64'd0);
    cyc();
    chk("rr2_req0_ready", 64'(bus.req0_ready), 64'd1);
    chk("rr2_id",         64'(bus.rsp_id), 64'd0);
    chk("rr2_result",     64'(bus.rsp_result), 64'd3);
    cyc();
    chk("rr3_req1_ready", 64'(bus.req1_ready), 64'd1);
    chk("rr3_id",         64'(bus.rsp_id), 64'd1);
    chk("rr3_result",     64'(bus.rsp_result), 64'h1E);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("rr4_id",         64'(bus.rsp_id), 64'd0);
    cyc();
    chk("rr5_id",         64'(bus.rsp_id), 64'd1);
    chk("rr5_result",     64'(bus.rsp_result), 64'h1E);
    chk("rr_flags",       64'(flags_q), 64'b0110);

    // Backpressure: R held, one op parked in S1, flags frozen until drain
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd6, 1'b1);
    settle();
    chk("bp_req0_ready",  64'(bus.req0_ready), 64'd1);
    cyc();
    set_req(0, 1'b1, OP_ADD, 32'd7, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_hold_ready",  64'(bus.req0_ready), 64'd0);
      chk("bp_hold_result", 64'(bus.rsp_result), 64'h1E);
      chk("bp_hold_flags",  64'(flags_q), 64'b0110);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("bp_drain_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("bp_a_result",    64'(bus.rsp_result), 64'hB);
    chk("bp_a_flags",     64'(flags_q), 64'd0);
    cyc();
    chk("bp_b_result",    64'(bus.rsp_result), 64'hF);
    chk("bp_b_flags",     64'(flags_q), 64'd0);

    // flags_ld beats a flag-setting advance in the same cycle
    set_req(0, 1'b1, OP_SUB, 32'd1, 32'd1, 1'b1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    flags_ld = 1'b1; flags_ld_val = 4'b1000;
    settle();
    cyc();
    flags_ld = 1'b0; flags_ld_val = 4'd0;
    settle();
    chk("ld_flags",       64'(flags_q), 64'b1000);
    chk("ld_result",      64'(bus.rsp_result), 64'd0);
    chk("ld_rsp_valid",   64'(bus.rsp_valid), 64'd1);

    // Reset with S1 and R both full; last grant went to req0
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b1);
    settle();
    chk("fill_req0_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    settle();
    cyc();
    reset = 1'b0;
    settle();
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_flags",     64'(flags_q), 64'd0);
    chk("mid_rst_result",    64'(bus.rsp_result), 64'd0);
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_AND, 32'd3, 32'd1, 1'b0);
    set_req(1, 1'b1, OP_AND, 32'd3, 32'd2, 1'b0);
    settle();
    chk("mid_rst_req0_wins", 64'(bus.req0_ready), 64'd1);
    chk("mid_rst_req1_wait", 64'(bus.req1_ready), 64'd0);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("mid_rst_s1_empty",  64'(bus.rsp_valid), 64'd0);
    cyc();
    chk("post_rst_result",   64'(bus.rsp_result), 64'd1);
    chk("post_rst_id",       64'(bus.rsp_id), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational ARM ALU between two requesters: port 0 (execute-stage datapath) and port 1 (address/aux unit).
- Round-robin arbitration, a one-entry operand stage and a one-entry response register.
- Owns the architectural flag register (N,Z,C,V) and feeds it back to the ALU as carry-in/flags.
- Sits between the decode/execute control and ARM_ALU.

Parameters:
- DW, 32, operand/result width
- OPW, 5, ALU opcode width
- FW, 4, flag width; bit order {N,Z,C,V} (bit1 = C)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  DW  operands
- req0_op  in  OPW  ALU opcode
- req0_s  in  1  update flags
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_s  same as port 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the result
- rsp_result  out  DW  ALU result
- rsp_wr  out  1  result is to be written back; 0 for TST/TEQ/CMP/CMN
- flags_q  out  FW  architectural flags
- flags_ld  in  1  direct flag load (MSR-style)
- flags_ld_val  in  FW  value for flags_ld
- alu_a, alu_b  out  DW  to ALU A/B
- alu_op  out  OPW  to ALU OP
- alu_flags  out  FW  to ALU FLAGS; always flags_q
- alu_s  out  1  to ALU S
- alu_out_en  out  1  to ALU ALU_OUT
- alu_result  in  DW  from ALU Out
- alu_flags_out  in  FW  from ALU FLAGS_OUT

Behaviour:
- Reset (synchronous): rsp_valid=0, stage valid=0, flags_q=0, rr pointer favours req0, req*_ready=0, rsp_result=0, rsp_id=0, rsp_wr=0, ALU outputs 0.
- A reset asserted mid-operation discards any in-flight stage or response, with no flag commit.
- Pipeline: operand stage S1, then response register R.
- advance = S1.valid & (!R.valid | rsp_ready).
- S1 may accept when !S1.valid | advance.
- Arbitration:
  - Only one req*_ready high per cycle.
  - Only one valid requester: that requester is granted.
  - Both valid: the requester not granted last time is granted.
  - The pointer updates only on an accepted transfer.
  - req*_ready is combinational from the valids and the pipeline state.
  - An accept loads S1 with {a,b,op,s,id}.
- ALU drive:
  - alu_a/alu_b/alu_op/alu_s come from S1.
  - alu_out_en = 0 when op is 8..11 (TST/TEQ/CMP/CMN), otherwise 1.
  - When S1 is empty, drive alu_s=0 and the last operands.
- Commit on advance:
  - R <= {alu_result, id, alu_out_en}; rsp_valid=1.
  - If S1.s, flags_q <= alu_flags_out.
- R holds its value while rsp_valid & !rsp_ready.
- rsp_valid drops after the handshake unless a new advance occurs in the same cycle.
- Latency: accept at edge k, response visible after edge k+1. Throughput is 1 op/clk with rsp_ready=1.
- No flag hazard: ADC/SBC/RSC in S1 see flags committed by the previous op at that same edge.
- flags_ld has priority over the ALU commit in the same cycle; the ALU flag update is dropped.
- Opcodes outside 0..17 are passed through unchanged; results are whatever the ALU returns.

Decomposition:
- Shared package: opcode constants (AND=0, XOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=10, CMN=11, ORR=12, MOV=13, BIC=14, MVN=15, BYPASS=16, INC=17).
- Shared package: flag bit indices N=3, Z=2, C=1, V=0.
- Shared package: function is_test_op(op).
- One sub-module: rr_arbiter2 (2-way round-robin with pointer update on accept).
- ARM_ALU is instantiated outside this block.

Test Plan:
- req0 ADD a=0xFB b=0xB s=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=0x106, rsp_id=0, rsp_wr=1, flags_q=0.
- req0 SUB 1,1 s=1, then ADC 0xF,0xF back-to-back -> first: result 0, flags_q=4'b0110; second: result 0x1F (carry used), flags_q=0.
- req1 CMP 0xF,0xF s=1 -> rsp_wr=0, rsp_id=1, alu_out_en=0 during exec, flags_q Z=1 C=1.
- Both valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
- rsp_ready=0 for 3 cycles with req0 valid -> R holds its value, one op waits in S1, req0_ready=0, flags_q unchanged until the drain.
- Both flags_ld (val=4'b1000) and a flag-setting advance in the same cycle -> flags_q=4'b1000.
- Reset while S1 and R are full -> next cycle rsp_valid=0, flags_q=0, req0 wins the next contention.
